// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: forms the sign-extended I/S/B/U/J immediate
// and hands it to the consumer through a two-entry skid buffer with a sideband tag.
module imm_gen_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [31:0]          instruction,
  input  logic [2:0]           immType,
  input  logic [TAG_WIDTH-1:0] inTag,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [XLEN-1:0]      extendedImm,
  output logic [TAG_WIDTH-1:0] outTag,
  output logic                 immErr
);

  localparam int unsigned IW = 32;

  localparam logic [2:0] TYPE_I = 3'd0;
  localparam logic [2:0] TYPE_S = 3'd1;
  localparam logic [2:0] TYPE_B = 3'd2;
  localparam logic [2:0] TYPE_U = 3'd3;
  localparam logic [2:0] TYPE_J = 3'd4;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                 accept, deliver;
  logic                 load_out_in, load_out_skid, load_skid;
  logic [IW-1:0]        imm32;
  logic                 imm_err_c;
  logic [XLEN-1:0]      imm_x;
  logic [XLEN-1:0]      skid_imm;
  logic [TAG_WIDTH-1:0] skid_tag;
  logic                 skid_err;
  logic                 unused_opcode;

  // Opcode field is decoded elsewhere; the format comes in on immType.
  assign unused_opcode = ^instruction[6:0];

  assign accept  = inValid & inReady;
  assign deliver = outValid & outReady;

  // Immediate formation at 32 bits, then sign-extend to XLEN.
  always_comb begin
    imm32     = '0;
    imm_err_c = 1'b0;
    case (immType)
      TYPE_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
      TYPE_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      TYPE_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
      TYPE_U: imm32 = {instruction[31:12], 12'b0};
      TYPE_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};
      default: begin
        imm32     = '0;
        imm_err_c = 1'b1;
      end
    endcase
    imm_x = XLEN'($signed(imm32));
  end

  // Occupancy FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      outValid <= 1'b0;
      inReady  <= 1'b1;
    end else begin
      state    <= state_nxt;
      outValid <= (state_nxt != EMPTY);
      inReady  <= (state_nxt != TWO);
    end
  end

  // Occupancy FSM: next state and load controls.
  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_out_in = 1'b1;
          state_nxt   = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end else if (deliver) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (deliver) begin
          load_out_skid = 1'b1;
          state_nxt     = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Output and skid storage; data outputs hold whenever not loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      extendedImm <= '0;
      outTag      <= '0;
      immErr      <= 1'b0;
      skid_imm    <= '0;
      skid_tag    <= '0;
      skid_err    <= 1'b0;
    end else begin
      if (load_out_in) begin
        extendedImm <= imm_x;
        outTag      <= inTag;
        immErr      <= imm_err_c;
      end else if (load_out_skid) begin
        extendedImm <= skid_imm;
        outTag      <= skid_tag;
        immErr      <= skid_err;
      end
      if (load_skid) begin
        skid_imm <= imm_x;
        skid_tag <= inTag;
        skid_err <= imm_err_c;
      end
    end
  end

endmodule
